// File: rtl/ucie_ctl_phy_xfer_sequencer.sv
// Link-level sequencer for the PHY data-transfer datapath.
// Walks the link through IDLE, TRAIN, ACTIVE, RETRAIN and DRAIN.
// Schedules single-beat error injection and counts delivered and errored beats.
// Forces a timed retrain once the number of errored beats reaches ERR_THRESH.
module ucie_ctl_phy_xfer_sequencer #(
  parameter int unsigned TRAIN_CYCLES   = 16,
  parameter int unsigned RETRAIN_CYCLES = 8,
  parameter int unsigned ERR_THRESH     = 4,
  parameter int unsigned DRAIN_MAX      = 32,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_link_up_req,
  input  logic                           i_link_down_req,
  input  logic                           i_err_inject_req,
  input  logic                           i_beat_valid,
  input  logic                           i_beat_error,
  output logic                           o_xfer_enable,
  output logic                           o_phy_req_data_error,
  output logic                           o_link_active,
  output logic                           o_retrain_pulse,
  output logic [2:0]                     o_state,
  output logic [CNT_W-1:0]               o_beat_count,
  output logic [$clog2(ERR_THRESH+1)-1:0] o_err_count
);

  localparam int unsigned ERR_W   = $clog2(ERR_THRESH + 1);
  localparam int unsigned TMR_MX1 = (TRAIN_CYCLES > RETRAIN_CYCLES) ? TRAIN_CYCLES : RETRAIN_CYCLES;
  localparam int unsigned TMR_MAX = (TMR_MX1 > DRAIN_MAX) ? TMR_MX1 : DRAIN_MAX;
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRAIN   = 3'd1,
    S_ACTIVE  = 3'd2,
    S_RETRAIN = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [CNT_W-1:0]   r_beat_count;
  logic [ERR_W-1:0]   r_err_count;
  logic               r_inject_pending;
  logic               r_retrain_pulse;

  logic               w_beat_err;
  logic               w_err_hit;
  logic               w_tmr_zero;
  logic               w_inject_fire;
  logic               w_clear;
  logic               w_counting;

  assign w_beat_err    = i_beat_valid & i_beat_error;
  // This errored beat is the one that brings the count up to the threshold.
  assign w_err_hit     = w_beat_err && (r_err_count == ERR_W'(ERR_THRESH - 1));
  assign w_tmr_zero    = (r_timer == '0);
  assign w_inject_fire = r_inject_pending && (r_state == S_ACTIVE) && i_beat_valid;
  // Counters and pending injection are wiped while idle and on the way into idle.
  assign w_clear       = (r_state == S_IDLE) || (w_state_nxt == S_IDLE);
  assign w_counting    = (r_state == S_ACTIVE) || (r_state == S_DRAIN);

  // Next-state and timer reload/decrement.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = w_tmr_zero ? r_timer : TMR_W'(r_timer - TMR_W'(1));
    case (r_state)
      S_IDLE: begin
        if (i_link_up_req && !i_link_down_req) begin
          w_state_nxt = S_TRAIN;
          w_timer_nxt = TMR_W'(TRAIN_CYCLES - 1);
        end
      end
      S_TRAIN: begin
        if (i_link_down_req) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmr_zero) begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (i_link_down_req) begin
          w_state_nxt = S_DRAIN;
          w_timer_nxt = TMR_W'(DRAIN_MAX - 1);
        end else if (w_err_hit) begin
          w_state_nxt = S_RETRAIN;
          w_timer_nxt = TMR_W'(RETRAIN_CYCLES - 1);
        end
      end
      S_RETRAIN: begin
        if (i_link_down_req) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmr_zero) begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_DRAIN: begin
        if (!i_beat_valid || w_tmr_zero) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and timer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Beat and error counters, injection bookkeeping and retrain pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat_count     <= '0;
      r_err_count      <= '0;
      r_inject_pending <= 1'b0;
      r_retrain_pulse  <= 1'b0;
    end else begin
      r_retrain_pulse <= (r_state == S_ACTIVE) && (w_state_nxt == S_RETRAIN);
      if (w_clear) begin
        r_beat_count     <= '0;
        r_err_count      <= '0;
        r_inject_pending <= 1'b0;
      end else begin
        if (w_counting && i_beat_valid && (r_beat_count != '1)) begin
          r_beat_count <= CNT_W'(r_beat_count + CNT_W'(1));
        end
        if (r_state == S_ACTIVE) begin
          if (w_state_nxt == S_RETRAIN) begin
            r_err_count <= '0;
          end else if (w_beat_err) begin
            r_err_count <= ERR_W'(r_err_count + ERR_W'(1));
          end
        end
        // Firing consumes the pending request; a request arriving that cycle is dropped.
        if (w_inject_fire) begin
          r_inject_pending <= 1'b0;
        end else if (i_err_inject_req) begin
          r_inject_pending <= 1'b1;
        end
      end
    end
  end

  assign o_xfer_enable        = (r_state == S_ACTIVE) || (r_state == S_DRAIN);
  assign o_link_active        = (r_state == S_ACTIVE);
  assign o_phy_req_data_error = w_inject_fire;
  assign o_retrain_pulse      = r_retrain_pulse;
  assign o_state              = r_state;
  assign o_beat_count         = r_beat_count;
  assign o_err_count          = r_err_count;

endmodule

// File: tb/tb_ucie_ctl_phy_xfer_sequencer.sv
// Self-checking bench for the PHY transfer sequencer: directed scenarios plus
// randomized traffic compared every cycle against a phase/elapsed-time model.
module tb_ucie_ctl_phy_xfer_sequencer;

  localparam int TRAIN_CYCLES   = 16;
  localparam int RETRAIN_CYCLES = 8;
  localparam int ERR_THRESH     = 4;
  localparam int DRAIN_MAX      = 32;
  localparam int CNT_W          = 16;
  localparam int ERR_W          = $clog2(ERR_THRESH + 1);

  localparam int P_IDLE = 0, P_TRAIN = 1, P_ACTIVE = 2, P_RETRAIN = 3, P_DRAIN = 4;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_link_up_req, i_link_down_req, i_err_inject_req, i_beat_valid, i_beat_error;
  logic o_xfer_enable, o_phy_req_data_error, o_link_active, o_retrain_pulse;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_beat_count;
  logic [ERR_W-1:0] o_err_count;

  int errors = 0;
  int checks = 0;

  ucie_ctl_phy_xfer_sequencer #(
    .TRAIN_CYCLES(TRAIN_CYCLES), .RETRAIN_CYCLES(RETRAIN_CYCLES),
    .ERR_THRESH(ERR_THRESH), .DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_link_up_req(i_link_up_req), .i_link_down_req(i_link_down_req),
    .i_err_inject_req(i_err_inject_req), .i_beat_valid(i_beat_valid),
    .i_beat_error(i_beat_error),
    .o_xfer_enable(o_xfer_enable), .o_phy_req_data_error(o_phy_req_data_error),
    .o_link_active(o_link_active), .o_retrain_pulse(o_retrain_pulse),
    .o_state(o_state), .o_beat_count(o_beat_count), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: current phase, cycles spent in it, and the counters.
  int m_phase = P_IDLE;
  int m_elapsed = 0;
  int m_beats = 0;
  int m_errs = 0;
  bit m_pend = 0;
  bit m_pulse = 0;

  // Compare on the falling edge, then advance the model using the inputs the DUT will sample.
  always @(negedge i_clk) begin
    bit e_en, e_inj, be;
    int nx;
    if (!i_rst_n) begin
      m_phase = P_IDLE; m_elapsed = 0; m_beats = 0; m_errs = 0; m_pend = 0; m_pulse = 0;
    end
    e_en  = (m_phase == P_ACTIVE) || (m_phase == P_DRAIN);
    e_inj = m_pend && (m_phase == P_ACTIVE) && i_beat_valid;
    check("m_state",   o_state, m_phase);
    check("m_enable",  o_xfer_enable, e_en);
    check("m_active",  o_link_active, m_phase == P_ACTIVE);
    check("m_inject",  o_phy_req_data_error, e_inj);
    check("m_pulse",   o_retrain_pulse, m_pulse);
    check("m_beats",   o_beat_count, m_beats);
    check("m_errs",    o_err_count, m_errs);
    if (i_rst_n) begin
      be = i_beat_valid && i_beat_error;
      nx = m_phase;
      case (m_phase)
        P_IDLE:    if (i_link_up_req && !i_link_down_req) nx = P_TRAIN;
        P_TRAIN:   if (i_link_down_req) nx = P_IDLE;
                   else if (m_elapsed == TRAIN_CYCLES - 1) nx = P_ACTIVE;
        P_ACTIVE:  if (i_link_down_req) nx = P_DRAIN;
                   else if (be && (m_errs + 1 == ERR_THRESH)) nx = P_RETRAIN;
        P_RETRAIN: if (i_link_down_req) nx = P_IDLE;
                   else if (m_elapsed == RETRAIN_CYCLES - 1) nx = P_ACTIVE;
        P_DRAIN:   if (!i_beat_valid || (m_elapsed == DRAIN_MAX - 1)) nx = P_IDLE;
        default:   nx = P_IDLE;
      endcase
      m_pulse = (m_phase == P_ACTIVE) && (nx == P_RETRAIN);
      if (e_en && i_beat_valid && (m_beats < (1 << CNT_W) - 1)) m_beats++;
      if ((m_phase == P_ACTIVE) && be) m_errs++;
      if (nx == P_RETRAIN) m_errs = 0;
      if (e_inj) m_pend = 0;
      else if ((m_phase != P_IDLE) && i_err_inject_req) m_pend = 1;
      if ((m_phase == P_IDLE) || (nx == P_IDLE)) begin
        m_beats = 0; m_errs = 0; m_pend = 0;
      end
      m_elapsed = (nx == m_phase) ? m_elapsed + 1 : 0;
      m_phase = nx;
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_active;
    int n = 0;
    while (o_state != 3'(P_ACTIVE) && n < 200) begin
      n++;
      tick();
    end
    check("wait_active", o_state, P_ACTIVE);
  endtask

  task automatic train_len(input string nm);
    int n = 0;
    while (o_state == 3'(P_TRAIN) && n < 100) begin
      n++;
      tick();
    end
    check(nm, n, TRAIN_CYCLES);
    check({nm, "_enable"}, o_xfer_enable, 1);
  endtask

  initial begin
    int n, p;
    i_rst_n = 1'b0;
    i_link_up_req = 0; i_link_down_req = 0; i_err_inject_req = 0;
    i_beat_valid = 0; i_beat_error = 0;
    repeat (3) tick();
    check("rst_state", o_state, 0);
    check("rst_enable", o_xfer_enable, 0);
    check("rst_beats", o_beat_count, 0);
    i_rst_n = 1'b1;
    tick();

    // T1 bring-up timing.
    i_link_up_req = 1;
    tick();
    check("t1_in_train", o_state, P_TRAIN);
    train_len("t1_train_len");

    // T2 injection fires on the first beat after the request, only once.
    i_err_inject_req = 1;
    tick();
    i_err_inject_req = 0;
    tick();
    tick();
    i_beat_valid = 1;
    #1;
    check("t2_inject_hit", o_phy_req_data_error, 1);
    tick();
    check("t2_second_clean", o_phy_req_data_error, 0);
    tick();
    i_beat_valid = 0;
    check("t2_beats", o_beat_count, 2);

    // T3 threshold of errored beats forces a retrain.
    i_beat_valid = 1; i_beat_error = 1;
    repeat (4) tick();
    i_beat_valid = 0; i_beat_error = 0;
    n = 0; p = 0;
    while (!o_xfer_enable && n < 100) begin
      p += int'(o_retrain_pulse);
      n++;
      tick();
    end
    check("t3_retrain_len", n, RETRAIN_CYCLES);
    check("t3_pulses", p, 1);
    check("t3_state", o_state, P_ACTIVE);
    check("t3_err_cleared", o_err_count, 0);
    check("t3_beats_held", o_beat_count, 6);

    // T4 link-down collides with the threshold beat: drain wins.
    i_beat_valid = 1; i_beat_error = 1;
    repeat (3) tick();
    i_link_down_req = 1;
    tick();
    check("t4_state_drain", o_state, P_DRAIN);
    check("t4_no_pulse", o_retrain_pulse, 0);
    check("t4_err_count", o_err_count, 4);
    check("t4_beats", o_beat_count, 10);
    i_beat_valid = 0; i_beat_error = 0;
    tick();
    check("t4_idle", o_state, P_IDLE);
    check("t4_beats_clr", o_beat_count, 0);
    check("t4_errs_clr", o_err_count, 0);
    i_link_down_req = 0;

    // T5 drain times out with beats still flowing.
    wait_active();
    i_beat_valid = 1; i_link_down_req = 1;
    tick();
    n = 0;
    while (o_state == 3'(P_DRAIN) && n < 100) begin
      n++;
      tick();
    end
    check("t5_drain_len", n, DRAIN_MAX);
    check("t5_idle", o_state, P_IDLE);
    i_link_down_req = 0; i_beat_valid = 0;

    // T6 asynchronous reset while retraining, then a clean relink.
    wait_active();
    i_beat_valid = 1; i_beat_error = 1;
    repeat (4) tick();
    i_beat_valid = 0; i_beat_error = 0;
    tick();
    tick();
    check("t6_in_retrain", o_state, P_RETRAIN);
    #2 i_rst_n = 1'b0;
    #1;
    check("t6_rst_enable", o_xfer_enable, 0);
    check("t6_rst_state", o_state, 0);
    check("t6_rst_beats", o_beat_count, 0);
    check("t6_rst_active", o_link_active, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check("t6_in_train", o_state, P_TRAIN);
    train_len("t6_train_len");

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      i_link_up_req    = ($urandom_range(0, 9) != 0);
      i_link_down_req  = ($urandom_range(0, 39) == 0);
      i_err_inject_req = ($urandom_range(0, 7) == 0);
      i_beat_valid     = ($urandom_range(0, 3) != 0);
      i_beat_error     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
